apb_master_arbiter: RTL and testbench

// - APB master bridge that shares one APB slave port (e.g. the APB memory slave) between NREQ requesters.
// - Round-robin arbitration, drives the APB IDLE/SETUP/ACCESS sequence, waits on Pready, and returns read data or error to the granted requester.
// - Sits between internal requesters (CPU stub, DMA, test driver) and the APB slave bus.
//

---
 rtl/apb_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/apb_master_arbiter.sv | 146 ++++++++++++++
 tb/tb_apb_master_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB master arbiter slice.
package apb_pkg;

  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request strictly after ptr_i.
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// APB master shared by NREQ requesters with round-robin grant,
// SETUP/ACCESS sequencing, wait-state timeout and registered responses.
module apb_master_arbiter
  import apb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int TIMEOUT = 16
) (
  input  logic             Pclk,
  input  logic             Prst,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [NREQ-1:0]  req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]  req_ready,
  output logic [NREQ-1:0]  rsp_valid,
  output logic [DW-1:0]    rsp_rdata,
  output logic             rsp_err,
  output logic [AW-1:0]    Paddr,
  output logic             Pselx,
  output logic             Penable,
  output logic             Pwrite,
  output logic [DW-1:0]    Pwdata,
  input  logic             Pready,
  input  logic             Pslverr,
  input  logic [DW-1:0]    Prdata
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  apb_state_e      state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   gidx_q, gidx_d;
  logic [AW-1:0]   paddr_q, paddr_d;
  logic            pwrite_q, pwrite_d;
  logic [DW-1:0]   pwdata_q, pwdata_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] req_ready_q, req_ready_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;
  logic            done;

  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;

  rr_arbiter #(.N(NREQ)) u_arb (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  always_ff @(posedge Pclk or posedge Prst) begin
    if (Prst) begin
      state_q     <= IDLE;
      ptr_q       <= IW'(NREQ - 1);
      gidx_q      <= '0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      cnt_q       <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gidx_q      <= gidx_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gidx_d      = gidx_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    cnt_d       = cnt_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          gidx_d      = arb_idx;
          ptr_d       = arb_idx;
          paddr_d     = req_addr[int'(arb_idx)*AW +: AW];
          pwrite_d    = req_write[arb_idx];
          pwdata_d    = req_wdata[int'(arb_idx)*DW +: DW];
          req_ready_d = arb_gnt;
          cnt_d       = '0;
          state_d     = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        // Pslverr only counts on the completing edge
        if (Pready) begin
          done        = 1'b1;
          rsp_err_d   = Pslverr;
          rsp_rdata_d = pwrite_q ? '0 : Prdata;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          done      = 1'b1;
          rsp_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        if (done) begin
          rsp_valid_d[gidx_q] = 1'b1;
          cnt_d               = '0;
          state_d             = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign Pselx     = (state_q != IDLE);
  assign Penable   = (state_q == ACCESS);
  assign Paddr     = paddr_q;
  assign Pwrite    = pwrite_q;
  assign Pwdata    = pwdata_q;
  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench: vector table of single transfers against a small APB slave
// model, plus reset-abort and round-robin fairness sequences.
module tb_apb_master_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int TO   = 16;

  logic              Pclk = 1'b0;
  logic              Prst;
  logic [NREQ-1:0]   req_valid, req_write;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]   req_ready, rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_err;
  logic [AW-1:0]     Paddr;
  logic              Pselx, Penable, Pwrite;
  logic [DW-1:0]     Pwdata;
  logic              Pready, Pslverr;
  logic [DW-1:0]     Prdata;

  int checks = 0;
  int errors = 0;

  apb_master_arbiter #(
    .NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TO)
  ) dut (
    .Pclk(Pclk), .Prst(Prst),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .Paddr(Paddr), .Pselx(Pselx), .Penable(Penable),
    .Pwrite(Pwrite), .Pwdata(Pwdata),
    .Pready(Pready), .Pslverr(Pslverr), .Prdata(Prdata)
  );

  always #5 Pclk = ~Pclk;

  // slave model: answers on negedge so Pready is settled for the next posedge
  logic [31:0] mem [0:15];
  int sl_cnt = 0;
  int sl_wait = 0;
  bit sl_err = 0;
  bit sl_stuck = 0;

  always @(negedge Pclk) begin
    if (Pselx && Penable) begin
      if (!sl_stuck && sl_cnt == sl_wait) begin
        Pready  = 1'b1;
        Pslverr = sl_err;
        Prdata  = mem[Paddr[5:2]];
        if (Pwrite && !sl_err) mem[Paddr[5:2]] = Pwdata;
      end else begin
        Pready  = 1'b0;
        Pslverr = 1'b1;
        Prdata  = 32'hBAD0BAD0;
      end
      sl_cnt++;
    end else begin
      Pready  = 1'b0;
      Pslverr = 1'b0;
      Prdata  = '0;
      sl_cnt  = 0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          idx;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    bit          err;
    bit          stuck;
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          exp_acc;
  } vec_t;

  vec_t vt [8];

  task automatic run(input vec_t v, input int vn);
    int n;
    int acc;
    bit stable_ok;
    logic [1:0] oh;
    oh = 2'b01 << v.idx;
    sl_wait  = v.waits;
    sl_err   = v.err;
    sl_stuck = v.stuck;
    req_write[v.idx]          = v.wr;
    req_addr[v.idx*AW +: AW]  = v.addr;
    req_wdata[v.idx*DW +: DW] = v.wdata;
    req_valid[v.idx]          = 1'b1;
    n = 0;
    do begin
      @(negedge Pclk);
      n++;
    end while (req_ready == '0 && n < 20);
    chk($sformatf("v%0d req_ready", vn), req_ready, oh);
    req_valid[v.idx] = 1'b0;
    chk($sformatf("v%0d setup", vn), {Pselx, Penable}, 2'b10);
    chk($sformatf("v%0d paddr", vn), Paddr, v.addr);
    chk($sformatf("v%0d pwrite", vn), Pwrite, v.wr);
    if (v.wr) chk($sformatf("v%0d pwdata", vn), Pwdata, v.wdata);
    acc = 0;
    stable_ok = 1'b1;
    @(negedge Pclk);
    while (Penable && acc < 40) begin
      acc++;
      if (!Pselx || Paddr !== v.addr || Pwrite !== v.wr) stable_ok = 1'b0;
      @(negedge Pclk);
    end
    chk($sformatf("v%0d access_cycles", vn), acc, v.exp_acc);
    chk($sformatf("v%0d stable", vn), stable_ok, 1);
    chk($sformatf("v%0d rsp_valid", vn), rsp_valid, oh);
    chk($sformatf("v%0d rsp_rdata", vn), rsp_rdata, v.exp_rdata);
    chk($sformatf("v%0d rsp_err", vn), rsp_err, v.exp_err);
    chk($sformatf("v%0d bus_idle", vn), {Pselx, Penable}, 2'b00);
    @(negedge Pclk);
    chk($sformatf("v%0d rsp_clear", vn),
        {rsp_valid, rsp_err, rsp_rdata}, '0);
  endtask

  initial begin
    int n;
    int g;
    bit seen;

    for (int i = 0; i < 16; i++) mem[i] = '0;
    //        idx wr addr      wdata         wt er st exp_rdata    eerr acc
    vt[0] = '{0, 1, 32'h04, 32'hDEADBEEF, 0, 0, 0, 32'h0,        0, 1};
    vt[1] = '{1, 0, 32'h04, 32'h0,        0, 0, 0, 32'hDEADBEEF, 0, 1};
    vt[2] = '{0, 1, 32'h08, 32'h12345678, 3, 0, 0, 32'h0,        0, 4};
    vt[3] = '{1, 0, 32'h08, 32'h0,        3, 0, 0, 32'h12345678, 0, 4};
    vt[4] = '{0, 0, 32'h04, 32'h0,        0, 1, 0, 32'hDEADBEEF, 1, 1};
    vt[5] = '{1, 1, 32'h0C, 32'hA5A5A5A5, 1, 1, 0, 32'h0,        1, 2};
    vt[6] = '{0, 0, 32'h0C, 32'h0,        0, 0, 0, 32'h0,        0, 1};
    vt[7] = '{1, 0, 32'h08, 32'h0,        0, 0, 1, 32'h0,        1, TO};

    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    Prst = 1'b1;
    repeat (2) @(negedge Pclk);
    chk("reset_bus", {Pselx, Penable, Pwrite}, 3'b000);
    chk("reset_paddr", Paddr, 32'h0);
    chk("reset_rsp", {req_ready, rsp_valid, rsp_err, rsp_rdata}, '0);
    Prst = 1'b0;

    // reset while stuck in ACCESS: bus must drop without a response
    sl_stuck = 1'b1;
    req_addr[AW-1:0] = 32'h20;
    req_valid[0] = 1'b1;
    n = 0;
    do begin
      @(negedge Pclk);
      n++;
      if (req_ready[0]) req_valid[0] = 1'b0;
    end while (!Penable && n < 20);
    chk("abort_reached_access", Penable, 1'b1);
    repeat (3) @(negedge Pclk);
    #2 Prst = 1'b1;
    #1;
    chk("abort_sel", {Pselx, Penable}, 2'b00);
    chk("abort_paddr", Paddr, 32'h0);
    chk("abort_rsp", {req_ready, rsp_valid, rsp_err}, '0);
    @(negedge Pclk);
    Prst = 1'b0;
    sl_stuck = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge Pclk);
      if (rsp_valid != '0 || Pselx) seen = 1'b1;
    end
    chk("abort_no_rsp", seen, 1'b0);

    // both requesters held valid: grants must alternate starting at 0
    sl_wait = 0;
    sl_err  = 0;
    req_write = 2'b00;
    req_addr  = {32'h14, 32'h10};
    req_valid = 2'b11;
    g = 0;
    n = 0;
    while (g < 4 && n < 60) begin
      @(negedge Pclk);
      n++;
      if (req_ready != '0) begin
        chk($sformatf("fair_grant%0d", g), req_ready,
            (g % 2 == 1) ? 2'b10 : 2'b01);
        g++;
      end
    end
    chk("fair_count", g, 4);
    req_valid = '0;
    repeat (6) @(negedge Pclk);

    for (int i = 0; i < 8; i++) run(vt[i], i);

    repeat (2) @(negedge Pclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
